// File: rtl/pc_unit.sv
// pc_unit: program counter with jump, increment, address mux and a LIFO return stack
module pc_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_en,
  input  logic        pc_ld,
  input  logic        pc_sel,
  input  logic [15:0] target,
  input  logic [15:0] data_addr,
  input  logic        call,
  input  logic        ret,
  output logic [15:0] mem_addr,
  output logic [15:0] pc,
  output logic [15:0] link,
  output logic        stack_empty,
  output logic        stack_full,
  output logic        stack_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [15:0] stack [DEPTH];
  logic [AW:0] count;
  logic [AW-1:0] top;
  logic jump, pop, push, err_set;
  logic [15:0] pc_nxt;
  assign top = count[AW-1:0] - AW'(1);
  assign stack_empty = count == '0;
  assign stack_full = count == FULL;
  assign link = stack_empty ? 16'h0000 : stack[top];
  assign mem_addr = pc_sel ? pc : data_addr;
  always_comb begin
    jump = pc_en & ~ret & pc_ld;
    pop = pc_en & ret & ~stack_empty;
    push = jump & call & ~stack_full;
    err_set = (pc_en & ret & stack_empty) | (jump & call & stack_full);
    pc_nxt = pop ? link : jump ? target : pc_en ? pc + 16'd1 : pc;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
      count <= '0;
      stack_err <= 1'b0;
    end else begin
      pc <= pc_nxt;
      count <= push ? count + 1'b1 : pop ? count - 1'b1 : count;
      stack_err <= stack_err | err_set;
    end
  end
  // entries need no reset: the count alone decides which are valid
  always_ff @(posedge clk) begin
    if (push) stack[count[AW-1:0]] <= pc;
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scoreboard bench for pc_unit (RESET_PC=0, DEPTH=4)
module tb_pc_unit;
  logic clk = 0, reset = 1, pc_en = 0, pc_ld = 0, pc_sel = 1, call = 0, ret = 0;
  logic [15:0] target = '0, data_addr = '0;
  logic [15:0] mem_addr, pc, link;
  logic stack_empty, stack_full, stack_err;
  int checks = 0, errors = 0;

  typedef struct {
    string tag;
    logic [15:0] pc, link;
    logic empty, full, err;
  } exp_t;
  exp_t sb[$];

  pc_unit dut (
    .clk(clk), .reset(reset), .pc_en(pc_en), .pc_ld(pc_ld), .pc_sel(pc_sel),
    .target(target), .data_addr(data_addr), .call(call), .ret(ret),
    .mem_addr(mem_addr), .pc(pc), .link(link), .stack_empty(stack_empty),
    .stack_full(stack_full), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [15:0] e_pc, e_link,
                              input logic e_em, e_fu, e_er);
    exp_t e;
    e.tag = tag; e.pc = e_pc; e.link = e_link; e.empty = e_em; e.full = e_fu; e.err = e_er;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard got empty expected entry");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".pc"}, pc, e.pc);
    chk({e.tag, ".link"}, link, e.link);
    chk({e.tag, ".empty"}, 16'(stack_empty), 16'(e.empty));
    chk({e.tag, ".full"}, 16'(stack_full), 16'(e.full));
    chk({e.tag, ".err"}, 16'(stack_err), 16'(e.err));
  endtask

  task automatic step(input string tag, input logic en, ld, cl, rt, input logic [15:0] tgt,
                      input logic [15:0] e_pc, e_link, input logic e_em, e_fu, e_er);
    @(negedge clk);
    pc_en = en; pc_ld = ld; call = cl; ret = rt; target = tgt; pc_sel = 1;
    expect_state(tag, e_pc, e_link, e_em, e_fu, e_er);
    @(posedge clk);
    #1;
    compare();
    chk({tag, ".mem_addr"}, mem_addr, e_pc);
  endtask

  initial begin
    #2;
    expect_state("reset", 16'h0000, 16'h0000, 1, 0, 0);
    compare();
    @(negedge clk);
    reset = 0;
    // increment and hold
    step("inc1", 1, 0, 0, 0, 16'h0000, 16'h0001, 16'h0000, 1, 0, 0);
    step("inc2", 1, 0, 0, 0, 16'h0000, 16'h0002, 16'h0000, 1, 0, 0);
    step("inc3", 1, 0, 0, 0, 16'h0000, 16'h0003, 16'h0000, 1, 0, 0);
    step("hold_ld", 0, 1, 0, 0, 16'h00AA, 16'h0003, 16'h0000, 1, 0, 0);
    step("hold_ret", 0, 0, 1, 1, 16'h00AA, 16'h0003, 16'h0000, 1, 0, 0);
    // address mux, combinational
    @(negedge clk);
    pc_en = 0; pc_sel = 0; data_addr = 16'h1234;
    #1 chk("mux_data", mem_addr, 16'h1234);
    pc_sel = 1;
    #1 chk("mux_pc", mem_addr, 16'h0003);
    // wrap
    step("jmp_ffff", 1, 1, 0, 0, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 0, 0);
    step("wrap", 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0);
    // call / return
    step("jmp_10", 1, 1, 0, 0, 16'h0010, 16'h0010, 16'h0000, 1, 0, 0);
    step("call", 1, 1, 1, 0, 16'h0200, 16'h0200, 16'h0010, 0, 0, 0);
    step("ret", 1, 0, 0, 1, 16'h0000, 16'h0010, 16'h0000, 1, 0, 0);
    // overflow
    step("c1", 1, 1, 1, 0, 16'h0100, 16'h0100, 16'h0010, 0, 0, 0);
    step("c2", 1, 1, 1, 0, 16'h0200, 16'h0200, 16'h0100, 0, 0, 0);
    step("c3", 1, 1, 1, 0, 16'h0300, 16'h0300, 16'h0200, 0, 0, 0);
    step("c4", 1, 1, 1, 0, 16'h0400, 16'h0400, 16'h0300, 0, 1, 0);
    step("c5_ovf", 1, 1, 1, 0, 16'h0500, 16'h0500, 16'h0300, 0, 1, 1);
    step("r1", 1, 0, 0, 1, 16'h0000, 16'h0300, 16'h0200, 0, 0, 1);
    step("r2", 1, 0, 0, 1, 16'h0000, 16'h0200, 16'h0100, 0, 0, 1);
    step("r3", 1, 0, 0, 1, 16'h0000, 16'h0100, 16'h0010, 0, 0, 1);
    step("r4", 1, 0, 0, 1, 16'h0000, 16'h0010, 16'h0000, 1, 0, 1);
    step("err_sticky", 1, 0, 0, 0, 16'h0000, 16'h0011, 16'h0000, 1, 0, 1);
    // reset clears error, then underflow and priority
    @(negedge clk);
    reset = 1; pc_en = 0; pc_ld = 0; call = 0; ret = 0;
    #1;
    expect_state("reset2", 16'h0000, 16'h0000, 1, 0, 0);
    compare();
    @(negedge clk);
    reset = 0;
    step("jmp_5", 1, 1, 0, 0, 16'h0005, 16'h0005, 16'h0000, 1, 0, 0);
    step("udf", 1, 0, 0, 1, 16'h0000, 16'h0006, 16'h0000, 1, 0, 1);
    step("call_40", 1, 1, 1, 0, 16'h0040, 16'h0040, 16'h0006, 0, 0, 1);
    step("prio", 1, 1, 0, 1, 16'h0999, 16'h0006, 16'h0000, 1, 0, 1);
    step("call_no_ld", 1, 0, 1, 0, 16'h0777, 16'h0007, 16'h0000, 1, 0, 1);
    // asynchronous reset with two entries at pc 0300
    step("a1", 1, 1, 1, 0, 16'h0100, 16'h0100, 16'h0007, 0, 0, 1);
    step("a2", 1, 1, 1, 0, 16'h0300, 16'h0300, 16'h0100, 0, 0, 1);
    pc_en = 0; pc_ld = 0; call = 0;
    #2 reset = 1;
    #1;
    expect_state("async_rst", 16'h0000, 16'h0000, 1, 0, 0);
    compare();
    chk("async_before_edge", 16'(clk), 16'h0001);
    @(negedge clk);
    reset = 0;
    step("post_rst", 1, 0, 0, 0, 16'h0000, 16'h0001, 16'h0000, 1, 0, 0);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain got %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
